// File: rtl/de_selector_nch_reg_pkg.sv
// de_selector_nch_reg_pkg: shared mode encodings and a clog2 helper for the de-selector
package de_selector_nch_reg_pkg;

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/de_selector_slot.sv
// de_selector_slot: one-entry holding register with valid flag for a single output channel
module de_selector_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    // a load wins over a drain on the same edge, so a refill keeps the slot full
    always_comb begin
        data_d  = load_i ? data_i : data_q;
        valid_d = load_i | (valid_q & ~ready_i);
    end

    // holding register; the data word survives a drain and is cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/de_selector_nch_reg.sv
// de_selector_nch_reg: registered 1-to-N de-selector with valid/ready handshakes and round-robin scan mode
module de_selector_nch_reg #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic [W-1:0]     iC,
    input  logic             iValid,
    output logic             oReady,
    input  logic [SEL_W-1:0] iS,
    input  logic             iMode,
    output logic [N*W-1:0]   oZ,
    output logic [N-1:0]     oZValid,
    input  logic [N-1:0]     iZReady,
    output logic [SEL_W-1:0] oScanPtr,
    output logic             oErr
);

    import de_selector_nch_reg_pkg::*;

    localparam int P = 2 ** SEL_W;

    if (clog2(N) > SEL_W) begin : g_sel_w_check
        $error("SEL_W is too narrow to address N channels");
    end

    logic [SEL_W-1:0] ptr_q, ptr_d, dest;
    logic             err_q, err_d;
    logic [N-1:0]     zvalid, load;
    logic [P-1:0]     zv_pad, zr_pad;
    logic             in_range, accept, scan;

    // destination select, combinational ready, and next pointer/error state
    always_comb begin
        scan     = mode_e'(iMode) == SCAN;
        dest     = scan ? ptr_q : iS;
        in_range = {1'b0, dest} < (SEL_W + 1)'(N);
        zv_pad   = P'(zvalid);
        zr_pad   = P'(iZReady);
        oReady   = in_range ? (~zv_pad[dest] | zr_pad[dest]) : 1'b1;
        accept   = iValid & oReady;
        err_d    = accept & ~in_range;
        ptr_d    = (accept & scan) ? ((ptr_q == SEL_W'(N - 1)) ? '0 : ptr_q + 1'b1) : ptr_q;
    end

    // scan pointer and one-cycle drop-error pulse
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign load[k] = accept & in_range & (dest == SEL_W'(k));
        de_selector_slot #(.W(W)) u_slot (
            .clk_i  (iClk),
            .rst_ni (iRst_n),
            .load_i (load[k]),
            .data_i (iC),
            .ready_i(iZReady[k]),
            .data_o (oZ[k*W +: W]),
            .valid_o(zvalid[k])
        );
    end

    assign oZValid  = zvalid;
    assign oScanPtr = ptr_q;
    assign oErr     = err_q;

endmodule

// File: tb/tb_de_selector_nch_reg.sv
// tb_de_selector_nch_reg: randomized scoreboard bench for the registered de-selector (N=3 build)
module tb_de_selector_nch_reg;

    localparam int W     = 8;
    localparam int N     = 3;
    localparam int SEL_W = 2;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     iC;
    logic             iValid;
    logic             oReady;
    logic [SEL_W-1:0] iS;
    logic             iMode;
    logic [N*W-1:0]   oZ;
    logic [N-1:0]     oZValid;
    logic [N-1:0]     iZReady;
    logic [SEL_W-1:0] oScanPtr;
    logic             oErr;

    de_selector_nch_reg #(.W(W), .N(N), .SEL_W(SEL_W)) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iC      (iC),
        .iValid  (iValid),
        .oReady  (oReady),
        .iS      (iS),
        .iMode   (iMode),
        .oZ      (oZ),
        .oZValid (oZValid),
        .iZReady (iZReady),
        .oScanPtr(oScanPtr),
        .oErr    (oErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [W-1:0] q[N][$];
    int           sp;
    int           err_exp;
    int           total;
    int           passed;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // monitor: each cycle compare per-channel fullness and pop/compare words the consumer takes
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                for (int k = 0; k < N; k++) begin
                    check($sformatf("zvalid%0d", k), int'(oZValid[k]), int'(q[k].size() != 0));
                    if (oZValid[k] && iZReady[k] && q[k].size() > 0) begin
                        logic [W-1:0] e;
                        e = q[k].pop_front();
                        check($sformatf("zdata%0d", k), int'(oZ[k*W +: W]), int'(e));
                    end
                end
            end
        end
    end

    task automatic cycle(input logic v, input logic [W-1:0] c, input logic [SEL_W-1:0] s,
                         input logic m, input logic [N-1:0] zr);
        int d;
        bit rdy;
        @(negedge clk);
        iValid  = v;
        iC      = c;
        iS      = s;
        iMode   = m;
        iZReady = zr;
        d   = m ? sp : int'(s);
        rdy = (d >= N) ? 1'b1 : (q[d].size() == 0 || zr[d]);
        #2;
        check("ready", int'(oReady), int'(rdy));
        check("scanptr", int'(oScanPtr), sp);
        check("err", int'(oErr), err_exp);
        @(posedge clk);
        err_exp = (v && rdy && d >= N) ? 1 : 0;
        if (v && rdy) begin
            if (d < N) q[d].push_back(c);
            if (m) sp = (sp + 1) % N;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        iValid = 1'b1;
        iC     = 8'h77;
        iS     = 2'd0;
        iMode  = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < N; k++) q[k].delete();
        sp      = 0;
        err_exp = 0;
        #1;
        check("rst_zvalid", int'(oZValid), 0);
        check("rst_z", int'(oZ), 0);
        check("rst_ptr", int'(oScanPtr), 0);
        check("rst_err", int'(oErr), 0);
        @(negedge clk);
        iValid = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        int left;
        total   = 0;
        passed  = 0;
        sp      = 0;
        err_exp = 0;
        rst_n   = 1'b1;
        iValid  = 1'b0;
        iC      = '0;
        iS      = '0;
        iMode   = 1'b0;
        iZReady = '0;
        #1 rst_n = 1'b0;
        #1;
        check("init_zvalid", int'(oZValid), 0);
        check("init_z", int'(oZ), 0);
        check("init_ptr", int'(oScanPtr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // direct load, stall on full channel, then same-edge drain and refill
        cycle(1, 8'hA5, 2, 0, 3'b000);
        cycle(1, 8'h3C, 2, 0, 3'b000);
        cycle(1, 8'h3C, 2, 0, 3'b100);
        cycle(0, 8'h00, 0, 0, 3'b000);
        // out-of-range drop in direct mode
        cycle(1, 8'hFF, 3, 0, 3'b000);
        cycle(0, 8'h00, 0, 0, 3'b000);
        cycle(0, 8'h00, 0, 0, 3'b111);
        // continuous scan stream with wrap
        for (int i = 0; i < 6; i++) cycle(1, 8'h10 + 8'(i), 0, 1, 3'b111);
        cycle(0, 8'h00, 0, 0, 3'b111);
        // reset with two channels full and a transfer pending
        cycle(1, 8'h01, 0, 0, 3'b000);
        cycle(1, 8'h02, 1, 0, 3'b000);
        do_reset();
        cycle(1, 8'hA5, 2, 0, 3'b000);
        cycle(0, 8'h00, 0, 0, 3'b111);
        // pointer retained across a mode switch
        cycle(1, 8'h21, 0, 1, 3'b111);
        cycle(1, 8'h22, 0, 1, 3'b111);
        cycle(1, 8'h23, 0, 0, 3'b111);
        cycle(1, 8'h24, 0, 1, 3'b111);
        cycle(0, 8'h00, 0, 0, 3'b111);
        // randomized traffic
        for (int i = 0; i < 500; i++)
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom), 3'($urandom));
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 0, 3'b111);
        left = 0;
        for (int k = 0; k < N; k++) left += q[k].size();
        check("undelivered", left, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/de_selector_nch_reg.md
Name: de_selector_nch_reg

Overview:
Registered, parametrised 1-to-N de-selector: the successor to the combinational 1-to-4 de-selector. Each accepted input word is steered into a one-entry holding register on the selected output channel. Input side and each output channel use valid/ready handshakes. A scan mode steps through the channels round-robin in place of the external select. Sits between a single producer and N independent consumers in lab datapaths.

Parameters:
W, 8, data width of iC and of each output channel
N, 4, number of output channels (2..16, need not be a power of two)
SEL_W, 2, width of iS; must satisfy 2**SEL_W >= N

Ports:
iClk  in  1  clock, rising edge
iRst_n  in  1  asynchronous, active-low reset
iC  in  W  input data word
iValid  in  1  input word present
oReady  out  1  block can accept iC this cycle
iS  in  SEL_W  destination channel select, used in direct mode
iMode  in  1  0 = direct (iS selects), 1 = scan (internal pointer selects)
oZ  out  N*W  channel data, channel k on bits [k*W +: W]
oZValid  out  N  per-channel holding register full
iZReady  in  N  per-channel consumer ready
oScanPtr  out  SEL_W  current scan pointer
oErr  out  1  one-cycle pulse: an out-of-range word was dropped

Behaviour:
- Reset (async, iRst_n=0): oZ=0, oZValid=0, oScanPtr=0, oErr=0. Held words are lost. Reset mid-transfer discards the word; no partial update.
- Destination: dest = iMode ? oScanPtr : iS. iMode and iS are sampled combinationally in the transfer cycle.
- In-range dest (dest < N): oReady = ~oZValid[dest] | iZReady[dest]. This is combinational and allows a same-cycle drain and refill.
- Out-of-range dest (direct mode only, dest >= N): oReady=1. The word is accepted and dropped. Next cycle oErr=1 for exactly one cycle. No channel changes state.
- Transfer condition: iValid & oReady at a rising edge. Latency is 1 cycle: on the next cycle oZ[dest]=iC and oZValid[dest]=1.
- Channel drain: oZValid[k] & iZReady[k] at an edge clears oZValid[k], unless the same edge refills channel k. In that case oZValid[k] stays 1 and oZ[k] takes the new word.
- Untouched channels hold their state. oZ[k] keeps its last value after a drain and is cleared only by reset.
- Scan pointer: advances by 1 on every accepted transfer in scan mode and wraps N-1 -> 0. It does not advance in direct mode or on a stall. A stall on a full scan channel blocks the input; it never skips that channel.
- Mode switch: oScanPtr keeps its value across iMode changes and resumes from there.
- iValid=0: no channel is written; oReady still reflects the dest state.
- All outputs except oReady are registered.

Decomposition:
- Shared constants header holds the mode encodings (DIRECT=0, SCAN=1) and a clog2 constant function used to check SEL_W.
- Sub-module de_selector_slot implements one channel's holding register and valid flag, with load/drain logic and W as a parameter. It is instantiated N times in a generate loop.
- The top level holds the dest mux, oReady logic, scan pointer and error pulse.

Test Plan:
- Reset, then direct mode with N=4, W=8; iC=8'hA5, iS=2, iValid=1 for 1 cycle, all iZReady=0 -> next cycle oZValid=4'b0100, oZ[2]=8'hA5, other channels 0.
- Channel 2 full with iZReady[2]=0; send 8'h3C to iS=2 -> oReady=0 and the word is held. Raise iZReady[2] -> same-edge drain and refill, so oZValid[2] stays 1 and oZ[2]=8'h3C.
- Scan mode, all iZReady=1; stream 8'h10..8'h15 continuously -> channels receive 10,11,12,13 then 14 on ch0 and 15 on ch1. oScanPtr runs 0,1,2,3,0,1,2 (wrap verified).
- N=3 build, direct mode, iS=3, iC=8'hFF -> oReady=1, oErr=1 for one cycle, oZValid unchanged.
- Assert iRst_n=0 between edges with 2 channels full and a transfer pending -> immediately oZValid=0, oZ=0, oScanPtr=0. After release the first transfer behaves as in scenario 1.
- Scan ptr=2, switch to direct mode, send to iS=0, switch back to scan -> the next scan word goes to ch2, proving the pointer was retained.
